uart_tx_scheduler: RTL and testbench

Shares the single UART TX serializer of a light-UART port between NUM_REQ byte sources, such as the binary file-stream loader and the xterm character path. Each character goes through the same sequence: arbitrate, handshake with the winning source, launch the serializer, wait for it to finish, then hold a programmable inter-character gap. The block sits between the byte producers and the bit-level TX shifter, one instance per UART port.

---
 rtl/uart_tx_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares one UART TX serializer between NUM_REQ byte sources. Each character
// is arbitrated, handshaken with the winning source, launched into the
// serializer, waited on until the serializer finishes, and followed by a
// programmable idle gap.
//
// Ports
//   clk         transactor clock
//   rst_n       synchronous reset, active low
//   req_valid   per-source byte-pending flags (held until accepted)
//   req_data    per-source bytes, source i at [i*DATA_W +: DATA_W]
//   req_ready   registered one-hot accept strobe (one cycle per character)
//   prio_mode   1: source 0 has strict priority, 0: pure round-robin
//   gap_cycles  idle clocks inserted after each character
//   ser_start   one-cycle launch pulse to the serializer
//   ser_data    byte presented to the serializer, held until the next capture
//   ser_busy    serializer busy flag
//   grant_id    index of the last granted source
//   active      high in every state except IDLE
//   char_count  characters launched since reset (wraps)
// ---------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int GAP_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        prio_mode,
  input  logic [GAP_W-1:0]            gap_cycles,
  output logic                        ser_start,
  output logic [DATA_W-1:0]           ser_data,
  input  logic                        ser_busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        active,
  output logic [31:0]                 char_count
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LAUNCH,
    S_WAIT_START,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t                r_state;
  logic [NUM_REQ-1:0]    r_req_ready;
  logic                  r_ser_start;
  logic [DATA_W-1:0]     r_ser_data;
  logic [IDX_W-1:0]      r_grant_id;
  logic                  r_active;
  logic [31:0]           r_char_count;
  logic [IDX_W-1:0]      r_rr_ptr;
  logic [GAP_W-1:0]      r_gap;

  logic                  w_any;
  logic                  w_found;
  logic [IDX_W-1:0]      w_win;
  logic [NUM_REQ-1:0]    w_onehot;
  logic [DATA_W-1:0]     w_src_data [NUM_REQ];

  // Index arithmetic modulo NUM_REQ; NUM_REQ need not be a power of two.
  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NUM_REQ);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_src
    assign w_src_data[g] = req_data[g*DATA_W +: DATA_W];
  end

  assign w_any = |req_valid;

  // Winner selection: source 0 overrides in priority mode, otherwise the
  // first valid source found scanning upward from the round-robin pointer.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    if (prio_mode && req_valid[0]) begin
      w_win   = '0;
      w_found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!w_found && req_valid[wrap_idx(int'(r_rr_ptr) + k)]) begin
          w_win   = wrap_idx(int'(r_rr_ptr) + k);
          w_found = 1'b1;
        end
      end
    end
  end

  assign w_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_req_ready  <= '0;
      r_ser_start  <= 1'b0;
      r_ser_data   <= '0;
      r_grant_id   <= '0;
      r_active     <= 1'b0;
      r_char_count <= '0;
      r_rr_ptr     <= '0;
      r_gap        <= '0;
    end else begin
      // The launch pulse is only ever raised on the GRANT exit edge.
      r_ser_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any && !ser_busy) begin
            r_req_ready <= w_onehot;
            r_grant_id  <= w_win;
            r_active    <= 1'b1;
            r_state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          r_req_ready <= '0;
          // A source that withdrew during its grant cycle is ignored and
          // the pointer is left where it was.
          if (req_valid[r_grant_id]) begin
            r_ser_data   <= w_src_data[r_grant_id];
            r_rr_ptr     <= wrap_idx(int'(r_grant_id) + 1);
            r_ser_start  <= 1'b1;
            r_char_count <= r_char_count + 32'd1;
            r_state      <= S_LAUNCH;
          end else begin
            r_active <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (ser_busy) begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (!ser_busy) begin
            if (gap_cycles == '0) begin
              r_active <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_gap   <= gap_cycles;
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          // Leaving on count 1 yields exactly gap_cycles cycles in GAP.
          if (r_gap == GAP_W'(1)) begin
            r_gap    <= '0;
            r_active <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_gap <= r_gap - GAP_W'(1);
          end
        end
        default: begin
          r_req_ready <= '0;
          r_active    <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign ser_start  = r_ser_start;
  assign ser_data   = r_ser_data;
  assign grant_id   = r_grant_id;
  assign active     = r_active;
  assign char_count = r_char_count;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Directed bench for uart_tx_scheduler (NUM_REQ=2, DATA_W=8, GAP_W=16).
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// the same point, so every check observes the state left by the last edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 8;
  localparam int GAP_W   = 16;

  logic                       clk;
  logic                       rst_n;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       prio_mode;
  logic [GAP_W-1:0]           gap_cycles;
  logic                       ser_start;
  logic [DATA_W-1:0]          ser_data;
  logic                       ser_busy;
  logic [0:0]                 grant_id;
  logic                       active;
  logic [31:0]                char_count;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_scheduler #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .GAP_W   (GAP_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .prio_mode  (prio_mode),
    .gap_cycles (gap_cycles),
    .ser_start  (ser_start),
    .ser_data   (ser_data),
    .ser_busy   (ser_busy),
    .grant_id   (grant_id),
    .active     (active),
    .char_count (char_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time bound so a stalled design can never hang the run.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "bench time limit expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full character with zero gap, starting from IDLE with the source
  // already valid. The source's byte is bumped after capture; drop clears
  // its valid flag at the same point.
  task automatic char_cycle(input string tag, input int id, input logic [7:0] exp_byte,
                            input int busy_len, input bit drop);
    logic [NUM_REQ-1:0] exp_ready;
    exp_ready = '0;
    exp_ready[id] = 1'b1;
    step();
    chk({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
    chk({tag, "_grant"}, 32'(grant_id), 32'(id));
    step();
    chk({tag, "_start"}, 32'(ser_start), 32'd1);
    chk({tag, "_data"}, 32'(ser_data), 32'(exp_byte));
    chk({tag, "_ready_off"}, 32'(req_ready), 32'd0);
    req_data[id*DATA_W +: DATA_W] = req_data[id*DATA_W +: DATA_W] + 8'd1;
    if (drop) req_valid[id] = 1'b0;
    step();
    chk({tag, "_start_off"}, 32'(ser_start), 32'd0);
    ser_busy = 1'b1;
    step();
    for (int i = 0; i < busy_len - 1; i++) step();
    ser_busy = 1'b0;
    step();
    chk({tag, "_idle"}, 32'(active), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    prio_mode  = 1'b0;
    gap_cycles = '0;
    ser_busy   = 1'b0;
    step();
    step();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_start", 32'(ser_start), 32'd0);
    chk("rst_data", 32'(ser_data), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_count", char_count, 32'd0);
    rst_n = 1'b1;

    // Single source, gap 4, 20-cycle serializer.
    gap_cycles = 16'd4;
    req_data[7:0] = 8'h41;
    req_valid = 2'b01;
    step();
    chk("single_ready", 32'(req_ready), 32'h1);
    chk("single_active", 32'(active), 32'd1);
    step();
    chk("single_start", 32'(ser_start), 32'd1);
    chk("single_data", 32'(ser_data), 32'h41);
    chk("single_count", char_count, 32'd1);
    chk("single_ready_off", 32'(req_ready), 32'd0);
    req_valid = 2'b00;
    step();
    chk("single_start_off", 32'(ser_start), 32'd0);
    ser_busy = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("single_busy_active", 32'(active), 32'd1);
    chk("single_hold", 32'(ser_data), 32'h41);
    ser_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("single_gap_active", 32'(active), 32'd1);
    end
    step();
    chk("single_gap_end", 32'(active), 32'd0);
    chk("single_hold_end", 32'(ser_data), 32'h41);

    // Reset to return the pointer to 0 before the round-robin run.
    rst_n = 1'b0;
    step();
    chk("rst2_count", char_count, 32'd0);
    rst_n = 1'b1;

    // Round-robin, both sources continuously valid.
    gap_cycles = '0;
    req_data = {8'h20, 8'h10};
    req_valid = 2'b11;
    char_cycle("rr0", 0, 8'h10, 2, 1'b0);
    char_cycle("rr1", 1, 8'h20, 2, 1'b0);
    char_cycle("rr2", 0, 8'h11, 2, 1'b0);
    char_cycle("rr3", 1, 8'h21, 2, 1'b0);
    char_cycle("rr4", 0, 8'h12, 2, 1'b0);
    char_cycle("rr5", 1, 8'h22, 2, 1'b0);
    chk("rr_count", char_count, 32'd6);

    // Strict priority: source 0 wins three times, then drops.
    prio_mode = 1'b1;
    char_cycle("pr0", 0, 8'h13, 2, 1'b0);
    char_cycle("pr1", 0, 8'h14, 2, 1'b0);
    char_cycle("pr2", 0, 8'h15, 2, 1'b1);
    char_cycle("pr3", 1, 8'h23, 2, 1'b1);
    prio_mode = 1'b0;

    // External serializer busy while IDLE holds off the grant.
    ser_busy = 1'b1;
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("busy_no_ready", 32'(req_ready), 32'd0);
      chk("busy_idle", 32'(active), 32'd0);
    end
    ser_busy = 1'b0;
    char_cycle("busy", 1, 8'h24, 3, 1'b1);

    // Reset during WAIT_DONE.
    req_valid = 2'b01;
    step();
    step();
    chk("mid_start", 32'(ser_start), 32'd1);
    req_valid = 2'b00;
    step();
    ser_busy = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    req_valid = 2'b10;
    step();
    chk("mid_rst_active", 32'(active), 32'd0);
    chk("mid_rst_start", 32'(ser_start), 32'd0);
    chk("mid_rst_count", char_count, 32'd0);
    chk("mid_rst_grant", 32'(grant_id), 32'd0);
    chk("mid_rst_data", 32'(ser_data), 32'd0);
    step();
    chk("mid_rst_no_ready", 32'(req_ready), 32'd0);
    ser_busy = 1'b0;
    rst_n = 1'b1;
    char_cycle("post_rst", 1, 8'h25, 2, 1'b1);
    chk("post_rst_count", char_count, 32'd1);

    // Zero gap with the character counter at its maximum.
    force dut.r_char_count = 32'hFFFF_FFFF;
    step();
    release dut.r_char_count;
    #1;
    chk("wrap_preload", char_count, 32'hFFFF_FFFF);
    req_valid = 2'b01;
    char_cycle("wrap", 0, 8'h16, 4, 1'b1);
    chk("wrap_count", char_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
